// File: rtl/nnue.sv
// NNUE evaluation engine: two per-player feature accumulators, updated one
// feature row per request, followed by a clipped-ReLU output dot product.
// Weights are fixed arithmetic functions of their indices, so nothing is loaded.
module nnue #(
    parameter int unsigned H     = 16,  // hidden neurons per accumulator (power of two)
    parameter int unsigned ACC_W = 16   // accumulator element width, signed
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic        player,
    input  logic [6:0]  row,
    input  logic        add,
    output logic        finish,
    output logic [15:0] out
);

    localparam int unsigned HW = $clog2(H);
    localparam int unsigned CW = $clog2(2 * H);
    localparam int unsigned XW = ACC_W + 2;

    localparam logic [CW-1:0] HCnt  = CW'(H);
    localparam logic [CW-1:0] HLast = CW'(H - 1);
    localparam logic [CW-1:0] KLast = CW'(2 * H - 1);

    // Accumulator saturation bounds in the widened update domain.
    localparam logic signed [XW-1:0]    AccMax  = XW'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [XW-1:0]    AccMin  = ~AccMax;
    localparam logic signed [ACC_W-1:0] ClipMax = ACC_W'(127);
    localparam logic signed [31:0]      OutMax  = 32'sd32767;
    localparam logic signed [31:0]      OutMin  = -32'sd32768;

    typedef enum logic [1:0] {
        StIdle,
        StUpdate,
        StEval,
        StDone
    } state_e;

    // First-layer weight: ((7f + 3h) mod 15) - 7, range -7..7.
    function automatic logic signed [4:0] w1(input logic [6:0] f, input logic [HW-1:0] h);
        int t;
        t = ((7 * int'(f) + 3 * int'(h)) % 15) - 7;
        return 5'(t);
    endfunction

    // Output-layer weight: ((5k) mod 15) - 7, range -7..3.
    function automatic logic signed [4:0] w2(input logic [CW-1:0] k);
        int t;
        t = ((5 * int'(k)) % 15) - 7;
        return 5'(t);
    endfunction

    state_e                    state_q, state_d;
    logic [CW-1:0]             idx_q, idx_d;
    logic [6:0]                row_q, row_d;
    logic                      add_q, add_d;
    logic                      player_q, player_d;
    logic signed [31:0]        sum_q, sum_d;
    logic [15:0]               out_q, out_d;
    logic                      finish_q, finish_d;
    logic                      acc_we;

    logic signed [ACC_W-1:0]   acc_q [2][H];

    logic signed [ACC_W-1:0]   upd_cur;
    logic signed [4:0]         upd_w;
    logic signed [XW-1:0]      upd_sum;
    logic signed [ACC_W-1:0]   upd_val;

    logic                      eval_sel;
    logic [HW-1:0]             eval_hid;
    logic signed [ACC_W-1:0]   eval_acc;
    logic [7:0]                eval_x;
    logic signed [31:0]        eval_prod;
    logic [15:0]               sat_out;

    // Saturating add/subtract of one W1 element into the selected accumulator element.
    always_comb begin
        upd_cur = acc_q[player_q][idx_q[HW-1:0]];
        upd_w   = w1(row_q, idx_q[HW-1:0]);
        if (add_q) begin
            upd_sum = XW'(upd_cur) + XW'(upd_w);
        end else begin
            upd_sum = XW'(upd_cur) - XW'(upd_w);
        end
        if (upd_sum > AccMax) begin
            upd_val = ACC_W'(AccMax);
        end else if (upd_sum < AccMin) begin
            upd_val = ACC_W'(AccMin);
        end else begin
            upd_val = ACC_W'(upd_sum);
        end
    end

    // One MAC operand: side to move feeds the first H inputs, the other side the rest.
    always_comb begin
        if (idx_q < HCnt) begin
            eval_sel = player_q;
            eval_hid = idx_q[HW-1:0];
        end else begin
            eval_sel = ~player_q;
            eval_hid = HW'(idx_q - HCnt);
        end
        eval_acc = acc_q[eval_sel][eval_hid];
        if (eval_acc[ACC_W-1]) begin
            eval_x = 8'd0;
        end else if (eval_acc > ClipMax) begin
            eval_x = 8'd127;
        end else begin
            eval_x = eval_acc[7:0];
        end
        eval_prod = $signed({24'd0, eval_x}) * 32'(w2(idx_q));
    end

    // Final score saturation to 16 bits.
    always_comb begin
        if (sum_q > OutMax) begin
            sat_out = 16'h7fff;
        end else if (sum_q < OutMin) begin
            sat_out = 16'h8000;
        end else begin
            sat_out = sum_q[15:0];
        end
    end

    // Next-state logic: IDLE -> UPDATE (H) -> EVAL (2H) -> DONE -> IDLE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        row_d    = row_q;
        add_d    = add_q;
        player_d = player_q;
        sum_d    = sum_q;
        out_d    = out_q;
        finish_d = 1'b0;
        acc_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    row_d    = row;
                    add_d    = add;
                    player_d = player;
                    idx_d    = '0;
                    sum_d    = '0;
                    state_d  = StUpdate;
                end
            end
            StUpdate: begin
                acc_we = 1'b1;
                if (idx_q == HLast) begin
                    idx_d   = '0;
                    state_d = StEval;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            StEval: begin
                sum_d = sum_q + eval_prod;
                if (idx_q == KLast) begin
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            StDone: begin
                out_d    = sat_out;
                finish_d = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            row_q    <= '0;
            add_q    <= 1'b0;
            player_q <= 1'b0;
            sum_q    <= '0;
            out_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            add_q    <= add_d;
            player_q <= player_d;
            sum_q    <= sum_d;
            out_q    <= out_d;
            finish_q <= finish_d;
        end
    end

    // Accumulator storage: one element written per UPDATE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                for (int unsigned h = 0; h < H; h++) begin
                    acc_q[p][h] <= '0;
                end
            end
        end else if (acc_we) begin
            acc_q[player_q][idx_q[HW-1:0]] <= upd_val;
        end
    end

    assign finish = finish_q;
    assign out    = out_q;

endmodule

// File: tb/tb_nnue.sv
// Scoreboard bench for nnue: the driver queues expected scores and finish
// cycles; a negedge monitor pops one entry per finish pulse and compares.
module tb_nnue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trigger;
    logic        player;
    logic [6:0]  row;
    logic        add;
    logic        finish;
    logic [15:0] out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int val;
        int fcyc;
    } exp_t;

    exp_t sb[$];
    int   macc[2][16];

    nnue #(.H(16), .ACC_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .trigger(trigger),
        .player (player),
        .row    (row),
        .add    (add),
        .finish (finish),
        .out    (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model of the weight formulas and evaluation.
    function automatic int w1m(input int f, input int h);
        return ((7 * f + 3 * h) % 15) - 7;
    endfunction

    function automatic int sat16m(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_apply(input int p, input int r, input bit a);
        int v;
        for (int h = 0; h < 16; h++) begin
            v = a ? macc[p][h] + w1m(r, h) : macc[p][h] - w1m(r, h);
            macc[p][h] = sat16m(v);
        end
    endtask

    function automatic int evalm(input int p);
        int s;
        int a;
        int x;
        s = 0;
        for (int k = 0; k < 32; k++) begin
            a = (k < 16) ? macc[p][k] : macc[1-p][k-16];
            x = (a < 0) ? 0 : ((a > 127) ? 127 : a);
            s += x * (((5 * k) % 15) - 7);
        end
        return sat16m(s);
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 2; p++)
            for (int h = 0; h < 16; h++)
                macc[p][h] = 0;
    endtask

    // Called at a negedge; raises trigger for exactly one edge, then scrambles inputs.
    task automatic start_op(input bit p, input int r, input bit a, input int hand, input bit use_model);
        int v;
        player  = p;
        row     = 7'(r);
        add     = a;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        model_apply(p, r, a);
        v = use_model ? evalm(p) : hand;
        sb.push_back('{val: v, fcyc: cyc + 49});
        @(negedge clk);
        trigger = 1'b0;
        row     = 7'($urandom);
        add     = 1'($urandom);
        player  = 1'($urandom);
    endtask

    // Returns at the negedge where finish is seen; bounded.
    task automatic wait_finish(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (finish === 1'b1) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=no_finish required=finish (cycle %0d)", name, cyc);
    endtask

    task automatic pulse_busy_trigger();
        trigger = 1'b1;
        row     = 7'd5;
        player  = 1'b0;
        add     = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    // Monitor: every finish must match the head of the scoreboard in value and timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && finish === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_finish actual=finish required=none out=%0d (cycle %0d)",
                         $signed(out), cyc);
            end else begin
                e = sb.pop_front();
                chk("score", int'($signed(out)), e.val);
                chk("finish_cycle", cyc, e.fcyc);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        trigger = 1'b0;
        player  = 1'b0;
        row     = 7'd0;
        add     = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out", int'($signed(out)), 0);
        chk("reset_finish", int'(finish), 0);

        // 1: first add on player 1.
        start_op(1'b1, 0, 1'b1, -42, 1'b0);
        wait_finish("s1");
        // 2: back-to-back, player 0 gets the same row.
        start_op(1'b0, 0, 1'b1, -84, 1'b0);
        wait_finish("s2");
        // 3: subtract row 0 from player 1.
        start_op(1'b1, 0, 1'b0, -42, 1'b0);
        wait_finish("s3");

        // 4: busy triggers ignored, out held until DONE.
        start_op(1'b1, 0, 1'b1, -84, 1'b0);
        repeat (8) @(negedge clk);
        chk("out_held_update", int'($signed(out)), -42);
        pulse_busy_trigger();
        repeat (20) @(negedge clk);
        chk("out_held_eval", int'($signed(out)), -42);
        pulse_busy_trigger();
        wait_finish("s4");

        // 5: reset mid-UPDATE aborts without a finish.
        @(negedge clk);
        player  = 1'b1;
        row     = 7'd0;
        add     = 1'b1;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        repeat (60) @(negedge clk);
        chk("abort_out", int'($signed(out)), 0);
        chk("abort_finish", int'(finish), 0);
        start_op(1'b1, 0, 1'b1, -42, 1'b0);
        wait_finish("s5_rerun");

        // 6: 26 back-to-back adds on player 1, clip at 127 exercised.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        for (int i = 0; i < 26; i++) begin
            if (i == 25) start_op(1'b1, 0, 1'b1, -1074, 1'b0);
            else start_op(1'b1, 0, 1'b1, 0, 1'b1);
            wait_finish("s6");
        end
        chk("model_acc_1_4", macc[1][4], 130);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
